seg_scan_display: RTL and testbench

Time-multiplexed driver for a NUM_DIGITS-digit common-anode seven-segment display on the board I/O path of the single-cycle CPU. Latches a packed hex word plus per-digit decimal points and blank controls into a shadow register on a load strobe. Scans the digits round-robin at a programmable rate and drives one registered anode vector and one registered active-low segment code. Replaces per-digit combinational decoding with one shared decoder, a prescaler and scan state.

---
 rtl/seg_scan_display.sv | 144 ++++++++++++++
 tb/tb_seg_scan_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed seven-segment scan driver; optional LEADING_ZERO_BLANK_EN
module seg_scan_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 100000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              dispcode
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              dispcode_q, dispcode_d;

  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_dark;

  // Shared hex decoder: segments g..a, active-low.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h58;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Prescaler, digit index and shadow register next-state.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (load) begin
      sh_data_d  = data_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
    end
  end

  // Leading-zero suppression: walk down from the top digit while nibbles and dps stay clear.
`ifdef LEADING_ZERO_BLANK_EN
  logic lz_quiet;
  always_comb begin
    suppress = '0;
    lz_quiet = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_quiet    = lz_quiet && (sh_data_q[4*i +: 4] == 4'h0) && !sh_dp_q[i];
      suppress[i] = lz_quiet;
    end
  end
`else
  // Suppression disabled: every non-blanked digit is shown.
  always_comb begin
    suppress = '0;
  end
`endif

  // Select the current digit and form the anode/segment pair registered together.
  always_comb begin
    sel_onehot = '0;
    sel_nib    = 4'h0;
    sel_dp     = 1'b0;
    sel_dark   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_nib       = sh_data_q[4*i +: 4];
        sel_dp        = sh_dp_q[i];
        sel_dark      = sh_blank_q[i] | suppress[i];
      end
    end
    if (sel_dark) begin
      an_d       = AN_OFF;
      dispcode_d = 8'hFF;
    end else begin
      an_d       = AN_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
      dispcode_d = {~sel_dp, seg_decode(sel_nib)};
    end
  end

  // State registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      an_q       <= AN_OFF;
      dispcode_q <= 8'hFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      an_q       <= an_d;
      dispcode_q <= dispcode_d;
    end
  end

  assign an       = an_q;
  assign dispcode = dispcode_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display against a behavioural scan model
module tb_seg_scan_display;
  localparam int N = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [7:0]  dispcode;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  int          m_t;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [7:0]  glyph [16];

  seg_scan_display #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (S),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .dp_in   (dp_in),
    .blank_in(blank_in),
    .an      (an),
    .dispcode(dispcode)
  );

  always #5 clk = ~clk;

  initial begin
    glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  end

  // Output expected at the next edge: digit shown is floor(t/S) mod N, taken from the current shadow.
  function automatic logic [11:0] model_out();
    int         idx;
    logic       dark;
    logic [3:0] nib;
    logic [7:0] code;
    logic [3:0] a;
    idx  = (m_t / S) % N;
    dark = m_blank[idx];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (m_data >> (4 * idx)) == 16'h0 && (m_dp >> idx) == 4'h0) dark = 1'b1;
`endif
    if (dark) return {4'hF, 8'hFF};
    nib     = 4'((m_data >> (4 * idx)) & 16'hF);
    code    = glyph[nib];
    code[7] = ~m_dp[idx];
    a       = ~(4'b0001 << idx);
    return {a, code};
  endfunction

  // Called at a negedge: drive inputs for the coming edge, queue its expected output, advance the model.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    load     = ld;
    data_in  = d;
    dp_in    = dp;
    blank_in = bl;
    exp_q.push_back(model_out());
    m_t = m_t + 1;
    if (ld) begin
      m_data  = d;
      m_dp    = dp;
      m_blank = bl;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (an !== 4'hF || dispcode !== 8'hFF) begin
      errors++;
      $display("FAIL %s an=%b dispcode=%h expected an=1111 dispcode=ff", name, an, dispcode);
    end
  endtask

  // Called at a negedge: asynchronous reset pulse, released on a later negedge.
  task automatic pulse_reset();
    load  = 1'b0;
    reset = 1'b1;
    #1;
    check_dark("async_reset");
    @(posedge clk);
    #1;
    check_dark("reset_held");
    @(negedge clk);
    reset   = 1'b0;
    m_t     = 0;
    m_data  = 16'h0;
    m_dp    = 4'h0;
    m_blank = 4'h0;
  endtask

  // Monitor: every edge with a queued expectation is compared just after the edge.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({an, dispcode} !== e) begin
          errors++;
          $display("FAIL scan_out at %0t: an=%b dispcode=%h expected an=%b dispcode=%h",
                   $time, an, dispcode, e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    data_in  = 16'h0;
    dp_in    = 4'h0;
    blank_in = 4'h0;
    m_t      = 0;
    m_data   = 16'h0;
    m_dp     = 4'h0;
    m_blank  = 4'h0;
    @(negedge clk);
    check_dark("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Free-running scan with zero data.
    idle(20);

    // Glyph and decimal-point decode.
    step(1'b1, 16'h3A7F, 4'b0010, 4'b0000);
    idle(16);

    // Forced blanking of digit 2.
    step(1'b1, 16'h1234, 4'b0000, 4'b0100);
    idle(16);

    // Load coinciding with an index advance.
    step(1'b1, 16'h0000, 4'b0000, 4'b0000);
    while ((m_t % S) != S - 1) idle(1);
    step(1'b1, 16'hFFFF, 4'b0000, 4'b0000);
    idle(8);

    // Reset in the middle of digit 2's dwell.
    while (!(((m_t / S) % N) == 2 && (m_t % S) == 1)) idle(1);
    pulse_reset();
    idle(10);

    // Leading-zero patterns.
    step(1'b1, 16'h0050, 4'b0000, 4'b0000);
    idle(16);
    step(1'b1, 16'h0000, 4'b0000, 4'b0000);
    idle(16);
    step(1'b1, 16'h0050, 4'b0100, 4'b0000);
    idle(16);

    // Load held high across several cycles.
    for (int i = 0; i < 12; i++) step(1'b1, 16'(16'h1111 * (i % 16)), 4'(i), 4'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 3) == 0, 16'($urandom()), 4'($urandom()),
             ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom()));
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
